// File: rtl/mux_rr_arbiter.sv
// Packet-level round-robin arbiter in front of a shared mux datapath.
// A grant is taken in IDLE, held in BUSY until the granted requester's
// last beat is accepted, then the search pointer moves past the winner.
// The data path is combinational from the inputs and the registered grant.

// Generic N:1 mux. AND-OR selection, so select codes with no matching input
// (possible when COUNT is not a power of two) produce zero.
module mux_generic #(
    parameter int COUNT = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic [COUNT-1:0][WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]            sel_i,
    output logic [WIDTH-1:0]            data_o
);

    // OR together every input whose index matches the select code
    always_comb begin
        data_o = '0;
        for (int i = 0; i < COUNT; i++) begin
            data_o = data_o | (data_i[i] & {WIDTH{sel_i == SEL_W'(i)}});
        end
    end

endmodule

module mux_rr_arbiter #(
    parameter int CHANNELS_COUNT = 4,
    parameter int CHANNELS_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [CHANNELS_COUNT-1:0]                     in_valid,
    input  logic [CHANNELS_COUNT-1:0]                     in_last,
    input  logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0] in_data,
    output logic [CHANNELS_COUNT-1:0]                     in_ready,
    output logic                                          out_valid,
    output logic                                          out_last,
    output logic [CHANNELS_WIDTH-1:0]                     out_data,
    input  logic                                          out_ready,
    output logic                                          grant_valid,
    output logic [$clog2(CHANNELS_COUNT)-1:0]             grant_idx
);

    localparam int IDX_W = (CHANNELS_COUNT > 1) ? $clog2(CHANNELS_COUNT) : 1;

    // Parameter sanity: a single requester or zero-width data makes no sense
    if (CHANNELS_COUNT < 2) begin : g_bad_count
        $fatal(1, "mux_rr_arbiter: CHANNELS_COUNT must be >= 2");
    end
    if (CHANNELS_WIDTH < 1) begin : g_bad_width
        $fatal(1, "mux_rr_arbiter: CHANNELS_WIDTH must be >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                      state_q;
    state_e                      state_d;
    logic [IDX_W-1:0]            grant_idx_q;
    logic [IDX_W-1:0]            grant_idx_d;
    logic [IDX_W-1:0]            rr_ptr_q;
    logic [IDX_W-1:0]            rr_ptr_d;

    logic                        hi_found_s;
    logic [IDX_W-1:0]            hi_idx_s;
    logic [IDX_W-1:0]            lo_idx_s;
    logic [IDX_W-1:0]            rr_pick_s;

    logic [CHANNELS_COUNT-1:0]   gnt_onehot_s;
    logic                        sel_valid_s;
    logic                        sel_last_s;
    logic [CHANNELS_WIDTH-1:0]   mux_data_s;

    // Round-robin search: lowest requester at or above rr_ptr wins; if none,
    // wrap to the lowest requester overall. Descending scan so the last
    // update is the lowest index.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = CHANNELS_COUNT - 1; i >= 0; i--) begin
            lo_idx_s   = in_valid[i] ? IDX_W'(i) : lo_idx_s;
            hi_idx_s   = (in_valid[i] && (IDX_W'(i) >= rr_ptr_q)) ? IDX_W'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (in_valid[i] & (IDX_W'(i) >= rr_ptr_q));
        end
        rr_pick_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Decode the held grant into a one-hot and pick the granted valid/last
    always_comb begin
        gnt_onehot_s = '0;
        sel_valid_s  = 1'b0;
        sel_last_s   = 1'b0;
        for (int i = 0; i < CHANNELS_COUNT; i++) begin
            gnt_onehot_s[i] = (grant_idx_q == IDX_W'(i));
            sel_valid_s     = sel_valid_s | (in_valid[i] & (grant_idx_q == IDX_W'(i)));
            sel_last_s      = sel_last_s  | (in_last[i]  & (grant_idx_q == IDX_W'(i)));
        end
    end

    mux_generic #(
        .COUNT (CHANNELS_COUNT),
        .WIDTH (CHANNELS_WIDTH),
        .SEL_W (IDX_W)
    ) u_mux (
        .data_i (in_data),
        .sel_i  (grant_idx_q),
        .data_o (mux_data_s)
    );

    // Next-state, pointer update and data-path outputs; IDLE forces all
    // outputs low so nothing leaks through during arbitration or reset
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        in_ready    = '0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|in_valid) begin
                    state_d     = ST_BUSY;
                    grant_idx_d = rr_pick_s;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_BUSY: begin
                out_valid = sel_valid_s;
                out_last  = sel_last_s;
                out_data  = mux_data_s;
                in_ready  = gnt_onehot_s & {CHANNELS_COUNT{out_ready}};
                if (sel_valid_s && out_ready && sel_last_s) begin
                    // Packet done: release, and advance modulo the channel count
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_idx_q == IDX_W'(CHANNELS_COUNT - 1)) ?
                               '0 : (grant_idx_q + IDX_W'(1'b1));
                end else begin
                    state_d  = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign grant_valid = (state_q == ST_BUSY);
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios on a 4-channel and a 3-channel
// instance, plus randomized traffic against a transaction-level model.
module tb_mux_rr_arbiter;

    logic             clk;
    logic             rst_n;

    logic [3:0]       iv;
    logic [3:0]       il;
    logic [3:0][7:0]  id;
    logic [3:0]       ir;
    logic             ov;
    logic             ol;
    logic [7:0]       od;
    logic             ordy;
    logic             gv;
    logic [1:0]       gi;

    logic [2:0]       iv3;
    logic [2:0]       il3;
    logic [2:0][7:0]  id3;
    logic [2:0]       ir3;
    logic             ov3;
    logic             ol3;
    logic [7:0]       od3;
    logic             ordy3;
    logic             gv3;
    logic [1:0]       gi3;

    int n_cmp;
    int n_err;

    mux_rr_arbiter #(.CHANNELS_COUNT(4), .CHANNELS_WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_last(il), .in_data(id), .in_ready(ir),
        .out_valid(ov), .out_last(ol), .out_data(od), .out_ready(ordy),
        .grant_valid(gv), .grant_idx(gi)
    );

    mux_rr_arbiter #(.CHANNELS_COUNT(3), .CHANNELS_WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv3), .in_last(il3), .in_data(id3), .in_ready(ir3),
        .out_valid(ov3), .out_last(ol3), .out_data(od3), .out_ready(ordy3),
        .grant_valid(gv3), .grant_idx(gi3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iv = 4'h0; il = 4'h0; id = '0; ordy = 1'b1;
        iv3 = 3'h0; il3 = 3'h0; id3 = '0; ordy3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv = 4'hF; il = 4'h0; id = {8'h44, 8'h33, 8'h22, 8'h11}; ordy = 1'b1;
        iv3 = 3'h7; il3 = 3'h0; id3 = {8'h66, 8'h55, 8'h77}; ordy3 = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({ov, ol, od, ir, gv, gi} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs4: got %h expected 0", {ov, ol, od, ir, gv, gi});
        end
        n_cmp++;
        if ({ov3, ol3, od3, ir3, gv3, gi3} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs3: got %h expected 0", {ov3, ol3, od3, ir3, gv3, gi3});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (gv !== 1'b1 || gi !== 2'd0) begin
            n_err++;
            $display("FAIL reset_first_grant: got gv=%b gi=%0d expected gv=1 gi=0", gv, gi);
        end
        n_cmp++;
        if (ov !== 1'b1 || od !== 8'h11 || ir !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_beat: got ov=%b od=%h ir=%b expected 1 11 0001", ov, od, ir);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] bc;
        logic [3:0] acc;
        logic       gv_prev;
        int         order[$];
        do_reset();
        iv = 4'hF; bc = 4'h0; gv_prev = 1'b0;
        for (int c = 0; c < 15; c++) begin
            il = bc;
            id = {8'h40 | {7'd0, bc[3]}, 8'h30 | {7'd0, bc[2]}, 8'h20 | {7'd0, bc[1]}, 8'h10 | {7'd0, bc[0]}};
            #1;
            n_cmp++;
            if (ov !== ((c % 3) != 0)) begin
                n_err++;
                $display("FAIL fair_beat_pattern c=%0d: got ov=%b expected %b", c, ov, ((c % 3) != 0));
            end
            if (gv && !gv_prev) order.push_back(int'(gi));
            gv_prev = gv;
            acc = ir & iv;
            @(posedge clk);
            bc = bc ^ acc;
            @(negedge clk);
        end
        iv = 4'h0; il = 4'h0;
        n_cmp++;
        if (order.size() != 5) begin
            n_err++;
            $display("FAIL fair_grant_count: got %0d expected 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (order[k] != (k % 4)) begin
                    n_err++;
                    $display("FAIL fair_order k=%0d: got %0d expected %0d", k, order[k], k % 4);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        iv = 4'b0010; il = 4'b0000; id = {8'h44, 8'h33, 8'h22, 8'h11};
        next_cycle();
        #1;
        n_cmp++;
        if (gv !== 1'b1 || gi !== 2'd1 || ir !== 4'b0010 || ov !== 1'b1 || od !== 8'h22) begin
            n_err++;
            $display("FAIL lock_grant1: got gv=%b gi=%0d ir=%b ov=%b od=%h expected 1 1 0010 1 22", gv, gi, ir, ov, od);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            iv = 4'b0100;
            #1;
            n_cmp++;
            if (gv !== 1'b1 || gi !== 2'd1 || ov !== 1'b0 || ir[2] !== 1'b0) begin
                n_err++;
                $display("FAIL lock_hold c=%0d: got gv=%b gi=%0d ov=%b ir=%b expected 1 1 0 ir[2]=0", c, gv, gi, ov, ir);
            end
        end
        next_cycle();
        iv = 4'b0110; il = 4'b0010;
        #1;
        n_cmp++;
        if (ov !== 1'b1 || ol !== 1'b1 || ir !== 4'b0010) begin
            n_err++;
            $display("FAIL lock_last: got ov=%b ol=%b ir=%b expected 1 1 0010", ov, ol, ir);
        end
        next_cycle();
        iv = 4'b0100; il = 4'b0000;
        #1;
        n_cmp++;
        if (gv !== 1'b0 || ov !== 1'b0 || ir !== 4'b0000) begin
            n_err++;
            $display("FAIL lock_bubble: got gv=%b ov=%b ir=%b expected 0 0 0000", gv, ov, ir);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (gv !== 1'b1 || gi !== 2'd2 || ir !== 4'b0100) begin
            n_err++;
            $display("FAIL lock_next_grant: got gv=%b gi=%0d ir=%b expected 1 2 0100", gv, gi, ir);
        end
        iv = 4'h0;
    endtask

    task automatic test_backpressure();
        logic [7:0] pkt [0:2];
        logic [7:0] got[$];
        logic       acc;
        int         b;
        int         stall;
        pkt[0] = 8'h11; pkt[1] = 8'hA5; pkt[2] = 8'h3C;
        b = 0; stall = 0;
        do_reset();
        for (int c = 0; c < 20 && b < 3; c++) begin
            iv[3] = 1'b1;
            id[3] = pkt[b];
            il[3] = (b == 2);
            ordy  = !(b == 1 && stall < 5);
            #1;
            if (!ordy) begin
                stall++;
                n_cmp++;
                if (od !== 8'hA5 || ir[3] !== 1'b0 || ov !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_hold stall=%0d: got od=%h ir=%b ov=%b expected a5 ir[3]=0 1", stall, od, ir, ov);
                end
            end
            acc = ir[3] && iv[3];
            if (acc) got.push_back(od);
            @(posedge clk);
            if (acc) b++;
            @(negedge clk);
        end
        iv = 4'h0; il = 4'h0; ordy = 1'b1;
        n_cmp++;
        if (b != 3 || got.size() != 3) begin
            n_err++;
            $display("FAIL bp_complete: got beats=%0d accepted=%0d expected 3 3 (timeout)", b, got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (got[k] !== pkt[k]) begin
                    n_err++;
                    $display("FAIL bp_data k=%0d: got %h expected %h", k, got[k], pkt[k]);
                end
            end
        end
        n_cmp++;
        if (stall != 5) begin
            n_err++;
            $display("FAIL bp_stall_count: got %0d expected 5", stall);
        end
    endtask

    task automatic test_wrap3();
        logic gv_prev;
        int   order[$];
        do_reset();
        iv3 = 3'b111; il3 = 3'b111; id3 = {8'hC2, 8'hC1, 8'hC0}; ordy3 = 1'b1;
        gv_prev = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_cmp++;
            if (gi3 === 2'd3 || ov3 !== ((c % 2) == 1)) begin
                n_err++;
                $display("FAIL wrap_cycle c=%0d: got gi=%0d ov=%b expected gi<3 ov=%b", c, gi3, ov3, ((c % 2) == 1));
            end
            if (gv3 && !gv_prev) order.push_back(int'(gi3));
            gv_prev = gv3;
            next_cycle();
        end
        iv3 = 3'h0; il3 = 3'h0;
        n_cmp++;
        if (order.size() != 4) begin
            n_err++;
            $display("FAIL wrap_grant_count: got %0d expected 4", order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (order[k] != (k % 3)) begin
                    n_err++;
                    $display("FAIL wrap_order k=%0d: got %0d expected %0d", k, order[k], k % 3);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        iv = 4'b0010; il = 4'b0010; id = {8'h44, 8'h33, 8'h22, 8'h11};
        next_cycle();
        next_cycle();
        iv = 4'b0100; il = 4'b0000;
        next_cycle();
        #1;
        n_cmp++;
        if (ov !== 1'b1 || gi !== 2'd2 || od !== 8'h33) begin
            n_err++;
            $display("FAIL areset_pre: got ov=%b gi=%0d od=%h expected 1 2 33", ov, gi, od);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ov, ol, od, ir, gv, gi} !== 17'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got %h expected 0", {ov, ol, od, ir, gv, gi});
        end
        iv = 4'hF;
        next_cycle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (gv !== 1'b1 || gi !== 2'd0) begin
            n_err++;
            $display("FAIL areset_restart: got gv=%b gi=%0d expected 1 0", gv, gi);
        end
        @(negedge clk);
        iv = 4'h0;
    endtask

    task automatic test_random();
        int    len[4];
        int    beat[4];
        bit    act[4];
        int    m_g;
        int    m_ptr;
        int    n_g;
        int    n_ptr;
        bit    m_busy;
        bit    n_busy;
        bit    acc;
        int    acc_ch;
        int    pkts;
        logic [16:0] e_v;
        logic [16:0] g_v;
        do_reset();
        m_busy = 1'b0; m_g = 0; m_ptr = 0; pkts = 0;
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0; len[i] = 1; beat[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!act[i] && $urandom_range(0, 3) == 0) begin
                    act[i] = 1'b1;
                    len[i] = $urandom_range(1, 4);
                    beat[i] = 0;
                    id[i] = 8'($urandom);
                end
                iv[i] = act[i] && ($urandom_range(0, 3) != 0);
                il[i] = act[i] && (beat[i] == len[i] - 1);
            end
            ordy = ($urandom_range(0, 4) != 0);
            #1;
            e_v = {m_busy ? iv[m_g] : 1'b0,
                   m_busy ? il[m_g] : 1'b0,
                   m_busy ? id[m_g] : 8'h00,
                   (m_busy && ordy) ? (4'b0001 << m_g) : 4'b0000,
                   m_busy,
                   2'(m_g)};
            g_v = {ov, ol, od, ir, gv, gi};
            n_cmp++;
            if (g_v !== e_v) begin
                n_err++;
                $display("FAIL random cyc=%0d: got {ov,ol,od,ir,gv,gi}=%h expected %h", cyc, g_v, e_v);
            end
            acc = m_busy && iv[m_g] && ordy;
            acc_ch = m_g;
            n_busy = m_busy; n_g = m_g; n_ptr = m_ptr;
            if (!m_busy) begin
                if (iv != 4'h0) begin
                    n_busy = 1'b1;
                    for (int k = 3; k >= 0; k--) begin
                        if (iv[(m_ptr + k) % 4]) n_g = (m_ptr + k) % 4;
                    end
                end
            end else if (acc && il[m_g]) begin
                n_busy = 1'b0;
                n_ptr = (m_g + 1) % 4;
            end
            @(posedge clk);
            m_busy = n_busy; m_g = n_g; m_ptr = n_ptr;
            @(negedge clk);
            if (acc) begin
                if (beat[acc_ch] == len[acc_ch] - 1) begin
                    act[acc_ch] = 1'b0;
                    pkts++;
                end else begin
                    beat[acc_ch]++;
                    id[acc_ch] = 8'($urandom);
                end
            end
        end
        iv = 4'h0; il = 4'h0;
        n_cmp++;
        if (pkts < 20) begin
            n_err++;
            $display("FAIL random_progress: got %0d packets expected at least 20", pkts);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_wrap3();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Packet-level round-robin arbiter that shares one `mux_generic` datapath between `CHANNELS_COUNT` valid/ready requesters. It registers the winning channel index, drives it as the mux select, and holds the grant until the granted requester's last beat is accepted downstream. It sits in front of any single-consumer sink (a FIFO or serializer) that several producers must share without interleaving packets.

## Interface

Parameters:

- `CHANNELS_COUNT`, 4: number of requesters; must be >= 2 (`$fatal` at elaboration otherwise).
- `CHANNELS_WIDTH`, 8: data width per channel; must be >= 1 (`$fatal` at elaboration otherwise).

Ports:

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, `CHANNELS_COUNT`: per-requester beat valid.
- `in_last`, input, `CHANNELS_COUNT`: per-requester end-of-packet marker; meaningful only while the matching `in_valid` bit is 1.
- `in_data`, input, `[CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0]`: per-requester data.
- `in_ready`, output, `CHANNELS_COUNT`: per-requester ready; at most one bit is ever 1.
- `out_valid`, output, 1: output beat valid.
- `out_last`, output, 1: output end-of-packet marker.
- `out_data`, output, `CHANNELS_WIDTH`: output data, driven through an internal `mux_generic` instance.
- `out_ready`, input, 1: downstream ready.
- `grant_valid`, output, 1: a packet grant is currently held.
- `grant_idx`, output, `$clog2(CHANNELS_COUNT)`: index of the granted requester; also the mux select.

## Operation

State machine with two states, IDLE and BUSY.

IDLE:
- `in_ready` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0.
- If any `in_valid` bit is 1:
  - Pick the first set bit searching upward from `rr_ptr`, wrapping from `CHANNELS_COUNT-1` to 0.
  - Register that index into `grant_idx`, set `grant_valid` = 1, go to BUSY.

BUSY, with `g` = `grant_idx`:
- `out_valid` = `in_valid[g]`.
- `out_last` = `in_last[g]`.
- `out_data` = `in_data[g]`.
- `in_ready[g]` = `out_ready`; all other `in_ready` bits are 0.
- Beat accepted = `out_valid && out_ready`.
- Accepted beat with `out_last` = 1:
  - Go to IDLE; `grant_valid` falls to 0.
  - `rr_ptr` <= `g+1`, or 0 if `g == CHANNELS_COUNT-1`. Pointer arithmetic is done modulo `CHANNELS_COUNT`, not modulo a power of two.
- Otherwise stay in BUSY. Grant is never revoked mid-packet, including while `in_valid[g]` is 0.

Other rules:
- `rr_ptr` is `$clog2(CHANNELS_COUNT)` bits and always holds a value < `CHANNELS_COUNT`.
- Requesters that are not granted see `in_ready` = 0 and must hold their beat (standard valid/ready).
- Reset (async assert): state = IDLE, `rr_ptr` = 0, `grant_idx` = 0, `grant_valid` = 0. All outputs go to 0 immediately, without waiting for a clock edge.
- Reset asserted mid-packet: the packet is abandoned. After reset release, arbitration restarts from channel 0.

## Timing

- Arbitration latency: one cycle. A request seen in IDLE at edge N is granted; its first beat can be accepted in the cycle after edge N.
- Bubble between packets: exactly one IDLE cycle after every last beat, even when other requesters are already pending.
- Steady-state throughput inside a packet: one beat per cycle while `in_valid[g]` and `out_ready` are both 1.
- The data path (`out_*` and `in_ready`) is combinational from the inputs plus registered `grant_idx`. No added data latency.
- A single-beat packet (`in_last` = 1 on the first beat) occupies 2 cycles: 1 IDLE + 1 BUSY.
- If all requesters are continuously active, each requester is granted once every `CHANNELS_COUNT` packets (no starvation).

## Test plan

- Reset: drive `rst_n`=0 with all `in_valid`=1 -> all outputs 0. Release, then next edge -> `grant_idx`=0, `grant_valid`=1.
- Fairness: N=4, all requesters send continuous 2-beat packets with `out_ready`=1 -> grant order 0,1,2,3,0. Each packet is 2 output beats followed by 1 idle cycle.
- Packet lock: channel 1 granted and `in_valid[1]` drops for 3 cycles while channel 2 requests -> `grant_idx` stays 1, `out_valid`=0, `in_ready[2]`=0. Channel 1 resumes and its `last` is accepted -> channel 2 granted next.
- Backpressure: `out_ready`=0 for 5 cycles mid-packet with data 0xA5 -> `out_data` held at 0xA5, `in_ready[g]`=0. No beat lost or duplicated after `out_ready` returns to 1.
- Non-power-of-two wrap: N=3, channel 2 finishes a packet with all channels requesting -> next grant is 0, never index 3.
- Async reset mid-packet: assert `rst_n` between clock edges during a BUSY beat -> outputs are 0 before the next edge. After release, arbitration restarts from channel 0.
